// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector scheduler: FSM encoding, grant encoding,
// engine handshake constants and the ring-pointer advance helper.
package sd_pkg;

    // Engine framing constants (one sector per CMD17/CMD24, sd_ck = clk / 12).
    localparam int unsigned SECTOR_BYTES   = 512;
    localparam int unsigned ENGINE_CLK_DIV = 12;

    typedef enum logic [3:0] {
        StPwr,
        StInitReq,
        StInitAck,
        StIdle,
        StRdReq,
        StRdAck,
        StWrReq,
        StWrAck,
        StErr
    } sd_state_e;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } sd_grant_e;

    // Advance a ring pointer, wrapping at depth-1 back to 0.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sd_ok_sync.sv
// Two-flop synchroniser for the engine's level completion flags.
module sd_ok_sync #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture of the flags into this clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sd_sector_scheduler.sv
// Sequences the SPI SD engine: power-up init, then round-robin arbitration of
// single-sector reads and writes over a circular sector ring on the card.
module sd_sector_scheduler
    import sd_pkg::*;
#(
    parameter logic [31:0] SEC_BASE  = 32'd0,
    parameter logic [31:0] SEC_DEPTH = 32'd1024,
    parameter logic [15:0] PWR_DLY   = 16'd4096,
    parameter logic [7:0]  ACK_HOLD  = 8'd32,
    parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_ok,
    input  logic        rd_ok,
    input  logic        wr_ok,
    output logic        sd_init,
    output logic        sd_ren,
    output logic        sd_wen,
    output logic [31:0] sec,
    output logic        fifo_busy,
    input  logic        wr_req,
    output logic        wr_gnt,
    output logic        wr_done,
    input  logic        rd_req,
    output logic        rd_gnt,
    output logic        rd_done,
    output logic [31:0] sec_count,
    output logic        full,
    output logic        empty,
    output logic        ready,
    output logic        err
);

    localparam logic [23:0] PwrLast = {8'd0, PWR_DLY} - 24'd1;
    localparam logic [23:0] AckLast = {16'd0, ACK_HOLD} - 24'd1;
    localparam logic [23:0] ToLast  = TIMEOUT - 24'd1;

    logic        init_ok_s;
    logic        rd_ok_s;
    logic        wr_ok_s;

    sd_ok_sync #(
        .Width (3)
    ) u_ok_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({init_ok, rd_ok, wr_ok}),
        .q_o   ({init_ok_s, rd_ok_s, wr_ok_s})
    );

    sd_state_e   state_q;
    sd_grant_e   last_q;
    logic [23:0] cnt_q;
    logic [31:0] wr_ptr_q;
    logic [31:0] rd_ptr_q;
    logic [31:0] count_q;
    logic [31:0] sec_q;
    logic        sd_init_q;
    logic        sd_ren_q;
    logic        sd_wen_q;
    logic        fifo_busy_q;
    logic        wr_gnt_q;
    logic        rd_gnt_q;
    logic        wr_done_q;
    logic        rd_done_q;
    logic        ready_q;
    logic        err_q;

    logic        full_w;
    logic        empty_w;
    logic        elig_rd;
    logic        elig_wr;
    logic        grant_rd;
    logic        grant_wr;
    logic        in_req;
    logic        ok_now;
    logic        timeout_hit;

    assign full_w  = (count_q == SEC_DEPTH);
    assign empty_w = (count_q == 32'd0);

    // Round-robin pick and timeout detection for the current state.
    always_comb begin
        elig_rd     = rd_req & ~empty_w;
        elig_wr     = wr_req & ~full_w;
        // On contention the side that did not complete last wins.
        grant_wr    = elig_wr & (~elig_rd | (last_q == GRANT_RD));
        grant_rd    = elig_rd & ~grant_wr;
        in_req      = (state_q == StInitReq) | (state_q == StRdReq) | (state_q == StWrReq);
        ok_now      = ((state_q == StInitReq) & init_ok_s) |
                      ((state_q == StRdReq) & rd_ok_s) |
                      ((state_q == StWrReq) & wr_ok_s);
        timeout_hit = in_req & ~ok_now & (cnt_q == ToLast);
    end

    // Sequencer FSM with registered engine and requester outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPwr;
            last_q      <= GRANT_WR;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sec_q       <= SEC_BASE;
            sd_init_q   <= 1'b0;
            sd_ren_q    <= 1'b0;
            sd_wen_q    <= 1'b0;
            fifo_busy_q <= 1'b0;
            wr_gnt_q    <= 1'b0;
            rd_gnt_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            cnt_q     <= cnt_q + 24'd1;
            if (timeout_hit) begin
                state_q     <= StErr;
                sd_init_q   <= 1'b0;
                sd_ren_q    <= 1'b0;
                sd_wen_q    <= 1'b0;
                fifo_busy_q <= 1'b0;
                wr_gnt_q    <= 1'b0;
                rd_gnt_q    <= 1'b0;
                ready_q     <= 1'b0;
                err_q       <= 1'b1;
            end else begin
                unique case (state_q)
                    StPwr: begin
                        if (cnt_q == PwrLast) begin
                            sd_init_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StInitReq;
                        end
                    end
                    StInitReq: begin
                        if (init_ok_s) begin
                            sd_init_q   <= 1'b0;
                            fifo_busy_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StInitAck;
                        end
                    end
                    StInitAck: begin
                        // Long enough for the engine to see fifo_busy on its slow clock.
                        if (cnt_q == AckLast) begin
                            fifo_busy_q <= 1'b0;
                            ready_q     <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StIdle;
                        end
                    end
                    StIdle: begin
                        if (grant_rd) begin
                            sec_q    <= SEC_BASE + rd_ptr_q;
                            sd_ren_q <= 1'b1;
                            rd_gnt_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StRdReq;
                        end else if (grant_wr) begin
                            sec_q    <= SEC_BASE + wr_ptr_q;
                            sd_wen_q <= 1'b1;
                            wr_gnt_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StWrReq;
                        end
                    end
                    StRdReq: begin
                        // Drop the request now so the engine does not re-issue on return to idle.
                        if (rd_ok_s) begin
                            sd_ren_q    <= 1'b0;
                            fifo_busy_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StRdAck;
                        end
                    end
                    StRdAck: begin
                        if (!rd_ok_s) begin
                            fifo_busy_q <= 1'b0;
                            rd_gnt_q    <= 1'b0;
                            rd_done_q   <= 1'b1;
                            rd_ptr_q    <= ptr_next(rd_ptr_q, SEC_DEPTH);
                            count_q     <= count_q - 32'd1;
                            last_q      <= GRANT_RD;
                            cnt_q       <= '0;
                            state_q     <= StIdle;
                        end
                    end
                    StWrReq: begin
                        if (wr_ok_s) begin
                            sd_wen_q    <= 1'b0;
                            fifo_busy_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StWrAck;
                        end
                    end
                    StWrAck: begin
                        if (!wr_ok_s) begin
                            fifo_busy_q <= 1'b0;
                            wr_gnt_q    <= 1'b0;
                            wr_done_q   <= 1'b1;
                            wr_ptr_q    <= ptr_next(wr_ptr_q, SEC_DEPTH);
                            count_q     <= count_q + 32'd1;
                            last_q      <= GRANT_WR;
                            cnt_q       <= '0;
                            state_q     <= StIdle;
                        end
                    end
                    StErr: begin
                        state_q <= StErr;
                    end
                    default: begin
                        state_q <= StErr;
                    end
                endcase
            end
        end
    end

    assign sd_init   = sd_init_q;
    assign sd_ren    = sd_ren_q;
    assign sd_wen    = sd_wen_q;
    assign sec       = sec_q;
    assign fifo_busy = fifo_busy_q;
    assign wr_gnt    = wr_gnt_q;
    assign wr_done   = wr_done_q;
    assign rd_gnt    = rd_gnt_q;
    assign rd_done   = rd_done_q;
    assign sec_count = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign ready     = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Bench for sd_sector_scheduler: two instances (general ring, and a small ring
// with a short timeout) driven by a simple engine model, checked against a
// transaction-level ring model (total writes/reads, round-robin last winner).
module tb_sd_sector_scheduler;

    localparam logic [31:0] BASE_A  = 32'h0000_0100;
    localparam logic [31:0] DEPTH_A = 32'd8;
    localparam int          PWR_A   = 64;
    localparam logic [31:0] BASE_B  = 32'h0000_0040;
    localparam logic [31:0] DEPTH_B = 32'd4;
    localparam int          PWR_B   = 16;
    localparam int          TO_B    = 100;

    logic        clk = 1'b0;
    logic [1:0]  rst_n, init_ok, rd_ok, wr_ok, sd_init, sd_ren, sd_wen, fifo_busy;
    logic [1:0]  wr_req, wr_gnt, wr_done, rd_req, rd_gnt, rd_done, full, empty, ready, err;
    logic [1:0]  rd_resp;
    logic [31:0] sec [2];
    logic [31:0] sec_count [2];

    int          checks = 0;
    int          errors = 0;
    int unsigned m_wr [2];
    int unsigned m_rd [2];
    bit          m_last_wr [2];
    int unsigned eng_cnt [2];
    int unsigned op_dly [2];

    always #5 clk = ~clk;

    sd_sector_scheduler #(
        .SEC_BASE (BASE_A), .SEC_DEPTH (DEPTH_A), .PWR_DLY (16'(PWR_A)),
        .ACK_HOLD (8'd32), .TIMEOUT (24'd5000)
    ) dut_a (
        .clk (clk), .rst_n (rst_n[0]), .init_ok (init_ok[0]), .rd_ok (rd_ok[0]),
        .wr_ok (wr_ok[0]), .sd_init (sd_init[0]), .sd_ren (sd_ren[0]), .sd_wen (sd_wen[0]),
        .sec (sec[0]), .fifo_busy (fifo_busy[0]), .wr_req (wr_req[0]), .wr_gnt (wr_gnt[0]),
        .wr_done (wr_done[0]), .rd_req (rd_req[0]), .rd_gnt (rd_gnt[0]), .rd_done (rd_done[0]),
        .sec_count (sec_count[0]), .full (full[0]), .empty (empty[0]), .ready (ready[0]),
        .err (err[0])
    );

    sd_sector_scheduler #(
        .SEC_BASE (BASE_B), .SEC_DEPTH (DEPTH_B), .PWR_DLY (16'(PWR_B)),
        .ACK_HOLD (8'd32), .TIMEOUT (24'(TO_B))
    ) dut_b (
        .clk (clk), .rst_n (rst_n[1]), .init_ok (init_ok[1]), .rd_ok (rd_ok[1]),
        .wr_ok (wr_ok[1]), .sd_init (sd_init[1]), .sd_ren (sd_ren[1]), .sd_wen (sd_wen[1]),
        .sec (sec[1]), .fifo_busy (fifo_busy[1]), .wr_req (wr_req[1]), .wr_gnt (wr_gnt[1]),
        .wr_done (wr_done[1]), .rd_req (rd_req[1]), .rd_gnt (rd_gnt[1]), .rd_done (rd_done[1]),
        .sec_count (sec_count[1]), .full (full[1]), .empty (empty[1]), .ready (ready[1]),
        .err (err[1])
    );

    function automatic int unsigned depth_of(input int u);
        return (u == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic int unsigned base_of(input int u);
        return (u == 0) ? BASE_A : BASE_B;
    endfunction

    // Engine model: raise the matching ok flag after a delay, clear it on fifo_busy.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n[g]) begin
                init_ok[g] <= 1'b0;
                rd_ok[g]   <= 1'b0;
                wr_ok[g]   <= 1'b0;
                eng_cnt[g] <= 0;
                op_dly[g]  <= 20;
            end else begin
                if (fifo_busy[g]) begin
                    rd_ok[g] <= 1'b0;
                    wr_ok[g] <= 1'b0;
                end
                if ((sd_init[g] && !init_ok[g]) || (sd_ren[g] && !rd_ok[g] && rd_resp[g]) ||
                    (sd_wen[g] && !wr_ok[g])) begin
                    if (eng_cnt[g] + 1 >= (sd_init[g] ? ((g == 0) ? 500 : 10) : op_dly[g])) begin
                        eng_cnt[g] <= 0;
                        if (sd_init[g]) init_ok[g] <= 1'b1;
                        if (sd_ren[g]) rd_ok[g] <= 1'b1;
                        if (sd_wen[g]) wr_ok[g] <= 1'b1;
                        op_dly[g] <= (g == 0) ? $urandom_range(4, 40) : 20;
                    end else begin
                        eng_cnt[g] <= eng_cnt[g] + 1;
                    end
                end else begin
                    eng_cnt[g] <= 0;
                end
            end
        end
    end

    // Continuous invariants: one engine request at a time, sec stable during a transaction.
    initial begin
        bit          prev_act [2];
        logic [31:0] prev_sec [2];
        prev_act = '{0, 0};
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst_n[u]) begin
                    checks++;
                    if ((int'(sd_init[u]) + int'(sd_ren[u]) + int'(sd_wen[u])) > 1) begin
                        errors++;
                        $display("FAIL onehot dut%0d: init/ren/wen=%b%b%b, required at most one",
                                 u, sd_init[u], sd_ren[u], sd_wen[u]);
                    end
                    if (prev_act[u] && (sd_ren[u] || sd_wen[u])) begin
                        checks++;
                        if (sec[u] !== prev_sec[u]) begin
                            errors++;
                            $display("FAIL sec_stable dut%0d: sec=%h, required %h", u, sec[u],
                                     prev_sec[u]);
                        end
                    end
                end
                prev_act[u] = rst_n[u] && (sd_ren[u] || sd_wen[u]);
                prev_sec[u] = sec[u];
            end
        end
    end

    // One transaction against the ring model; hold keeps the requests asserted.
    task automatic run_txn(input int u, input bit want_wr, input bit want_rd, input bit hold);
        int unsigned cnt, exp_sec;
        bit          e_wr, e_rd, g_wr, g_rd, found;
        cnt  = m_wr[u] - m_rd[u];
        e_wr = want_wr && (cnt < depth_of(u));
        e_rd = want_rd && (cnt > 0);
        g_wr = e_wr && (!e_rd || !m_last_wr[u]);
        g_rd = e_rd && !g_wr;
        wr_req[u] = want_wr;
        rd_req[u] = want_rd;
        if (!g_wr && !g_rd) begin
            repeat (20) @(negedge clk);
            checks++;
            if ({wr_gnt[u], rd_gnt[u], sd_wen[u], sd_ren[u]} !== 4'b0000) begin
                errors++;
                $display("FAIL no_grant dut%0d: gnt_w/gnt_r/wen/ren=%b%b%b%b, required 0000", u,
                         wr_gnt[u], rd_gnt[u], sd_wen[u], sd_ren[u]);
            end
            if (!hold) begin
                wr_req[u] = 1'b0;
                rd_req[u] = 1'b0;
            end
            return;
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = wr_gnt[u] | rd_gnt[u];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL grant_wait dut%0d: no grant, required w/r=%b%b", u, g_wr, g_rd);
            wr_req[u] = 1'b0;
            rd_req[u] = 1'b0;
            return;
        end
        checks++;
        if ({wr_gnt[u], rd_gnt[u]} !== {g_wr, g_rd}) begin
            errors++;
            $display("FAIL grant_kind dut%0d: w/r=%b%b, required %b%b", u, wr_gnt[u], rd_gnt[u],
                     g_wr, g_rd);
        end
        exp_sec = base_of(u) + (g_wr ? (m_wr[u] % depth_of(u)) : (m_rd[u] % depth_of(u)));
        checks++;
        if (sec[u] !== exp_sec) begin
            errors++;
            $display("FAIL sec dut%0d: sec=%h, required %h", u, sec[u], exp_sec);
        end
        checks++;
        if ({sd_wen[u], sd_ren[u]} !== {g_wr, g_rd}) begin
            errors++;
            $display("FAIL sd_en dut%0d: wen/ren=%b%b, required %b%b", u, sd_wen[u], sd_ren[u],
                     g_wr, g_rd);
        end
        if (!hold) begin
            wr_req[u] = 1'b0;
            rd_req[u] = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = wr_done[u] | rd_done[u];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_wait dut%0d: no done pulse, required w/r=%b%b", u, g_wr, g_rd);
            wr_req[u] = 1'b0;
            rd_req[u] = 1'b0;
            return;
        end
        checks++;
        if ({wr_done[u], rd_done[u]} !== {g_wr, g_rd}) begin
            errors++;
            $display("FAIL done_kind dut%0d: w/r=%b%b, required %b%b", u, wr_done[u], rd_done[u],
                     g_wr, g_rd);
        end
        if (g_wr) m_wr[u]++;
        else m_rd[u]++;
        m_last_wr[u] = g_wr;
        cnt = m_wr[u] - m_rd[u];
        checks++;
        if (sec_count[u] !== cnt) begin
            errors++;
            $display("FAIL count dut%0d: sec_count=%0d, required %0d", u, sec_count[u], cnt);
        end
        checks++;
        if ({full[u], empty[u]} !== {cnt == depth_of(u), cnt == 0}) begin
            errors++;
            $display("FAIL flags dut%0d: full/empty=%b%b, required %b%b", u, full[u], empty[u],
                     cnt == depth_of(u), cnt == 0);
        end
        @(negedge clk);
        checks++;
        if ({wr_done[u], rd_done[u]} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse dut%0d: w/r=%b%b one cycle later, required 00", u,
                     wr_done[u], rd_done[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({sd_init[u], sd_ren[u], sd_wen[u], fifo_busy[u], wr_gnt[u], wr_done[u], rd_gnt[u],
                 rd_done[u], full[u], empty[u], ready[u], err[u]} !== 12'b0000_0000_0100) begin
                errors++;
                $display("FAIL reset_flags dut%0d: got %b, required 000000000100", u,
                         {sd_init[u], sd_ren[u], sd_wen[u], fifo_busy[u], wr_gnt[u], wr_done[u],
                          rd_gnt[u], rd_done[u], full[u], empty[u], ready[u], err[u]});
            end
            checks++;
            if (sec[u] !== base_of(u) || sec_count[u] !== 32'd0) begin
                errors++;
                $display("FAIL reset_sec dut%0d: sec=%h count=%0d, required %h 0", u, sec[u],
                         sec_count[u], base_of(u));
            end
        end
    endtask

    task automatic test_power_up();
        int n;
        bit found;
        // Requests before ready must be ignored.
        wr_req[0] = 1'b1;
        rd_req[0] = 1'b1;
        rst_n     = 2'b11;
        found     = 1'b0;
        n         = 0;
        for (int i = 1; i <= PWR_A + 10 && !found; i++) begin
            @(negedge clk);
            if (sd_init[0]) begin
                found = 1'b1;
                n     = i;
            end
        end
        checks++;
        if (!found || n < PWR_A - 1 || n > PWR_A + 1) begin
            errors++;
            $display("FAIL pwr_dly: sd_init rose after %0d clk (seen=%0d), required %0d", n, found,
                     PWR_A);
        end
        checks++;
        if ({wr_gnt[0], rd_gnt[0]} !== 2'b00) begin
            errors++;
            $display("FAIL early_req: gnt w/r=%b%b before ready, required 00", wr_gnt[0],
                     rd_gnt[0]);
        end
        wr_req[0] = 1'b0;
        rd_req[0] = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            found = init_ok[0];
        end
        n = 0;
        while (sd_init[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!found || sd_init[0] || n > 3) begin
            errors++;
            $display("FAIL init_drop: sd_init fell %0d clk after init_ok (ok=%0d), required <=3",
                     n, found);
        end
        n = 0;
        while (fifo_busy[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL ack_hold: fifo_busy high %0d clk, required 32", n);
        end
        checks++;
        if (ready[0] !== 1'b1 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready: ready/err=%b%b, required 10", ready[0], err[0]);
        end
    endtask

    task automatic test_write_read();
        run_txn(0, 1'b1, 1'b0, 1'b0);
        run_txn(0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_empty: empty=%b, required 1", empty[0]);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 5; i++) run_txn(0, 1'b1, 1'b0, 1'b0);
        // Both held high throughout; the last call lets go after its grant.
        for (int i = 0; i < 4; i++) run_txn(0, 1'b1, 1'b1, i < 3);
        checks++;
        if (sec_count[0] !== 32'd5) begin
            errors++;
            $display("FAIL contention_count: sec_count=%0d, required 5", sec_count[0]);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 2);
            run_txn(0, op != 1, op != 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        bit found;
        if (m_wr[0] - m_rd[0] == DEPTH_A) run_txn(0, 1'b0, 1'b1, 1'b0);
        wr_req[0] = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = wr_gnt[0];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midwr_grant: wr_gnt=%b, required 1", wr_gnt[0]);
        end
        wr_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if ({sd_init[0], sd_ren[0], sd_wen[0], fifo_busy[0], wr_gnt[0], wr_done[0], rd_gnt[0],
             rd_done[0], full[0], empty[0], ready[0], err[0]} !== 12'b0000_0000_0100) begin
            errors++;
            $display("FAIL midwr_flags: got %b, required 000000000100",
                     {sd_init[0], sd_ren[0], sd_wen[0], fifo_busy[0], wr_gnt[0], wr_done[0],
                      rd_gnt[0], rd_done[0], full[0], empty[0], ready[0], err[0]});
        end
        checks++;
        if (sec[0] !== BASE_A || sec_count[0] !== 32'd0) begin
            errors++;
            $display("FAIL midwr_sec: sec=%h count=%0d, required %h 0", sec[0], sec_count[0],
                     BASE_A);
        end
        m_wr[0]      = 0;
        m_rd[0]      = 0;
        m_last_wr[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n[0] = 1'b1;
        found    = 1'b0;
        n        = 0;
        for (int i = 1; i <= PWR_A + 10 && !found; i++) begin
            @(negedge clk);
            if (sd_init[0]) begin
                found = 1'b1;
                n     = i;
            end
        end
        checks++;
        if (!found || n < PWR_A - 1 || n > PWR_A + 1) begin
            errors++;
            $display("FAIL midwr_reinit: sd_init rose after %0d clk, required %0d", n, PWR_A);
        end
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            @(negedge clk);
            found = ready[0];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midwr_ready: ready=%b, required 1", ready[0]);
        end
        run_txn(0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_full();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = ready[1];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b_ready: ready=%b, required 1", ready[1]);
        end
        for (int i = 0; i < 4; i++) run_txn(1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (full[1] !== 1'b1) begin
            errors++;
            $display("FAIL full: full=%b, required 1", full[1]);
        end
        run_txn(1, 1'b1, 1'b0, 1'b0);
        run_txn(1, 1'b0, 1'b1, 1'b0);
        run_txn(1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (sec[1] !== BASE_B) begin
            errors++;
            $display("FAIL wrap_sec: sec=%h, required %h", sec[1], BASE_B);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit found;
        rd_resp[1] = 1'b0;
        rd_req[1]  = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = rd_gnt[1];
        end
        rd_req[1] = 1'b0;
        n = 0;
        while (!err[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!found || n < TO_B - 2 || n > TO_B + 2) begin
            errors++;
            $display("FAIL timeout: err after %0d clk (granted=%0d), required about %0d", n, found,
                     TO_B);
        end
        checks++;
        if ({sd_ren[1], rd_gnt[1], fifo_busy[1], ready[1], err[1]} !== 5'b00001) begin
            errors++;
            $display("FAIL err_outputs: ren/gnt/busy/ready/err=%b, required 00001",
                     {sd_ren[1], rd_gnt[1], fifo_busy[1], ready[1], err[1]});
        end
        wr_req[1] = 1'b1;
        rd_req[1] = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if ({wr_gnt[1], rd_gnt[1], sd_wen[1], sd_ren[1], err[1]} !== 5'b00001) begin
            errors++;
            $display("FAIL err_sticky: gnt_w/gnt_r/wen/ren/err=%b, required 00001",
                     {wr_gnt[1], rd_gnt[1], sd_wen[1], sd_ren[1], err[1]});
        end
        wr_req[1] = 1'b0;
        rd_req[1] = 1'b0;
    endtask

    initial begin
        rst_n     = 2'b00;
        wr_req    = 2'b00;
        rd_req    = 2'b00;
        rd_resp   = 2'b11;
        m_wr      = '{0, 0};
        m_rd      = '{0, 0};
        m_last_wr = '{1, 1};
        repeat (3) @(negedge clk);
        test_reset();
        test_power_up();
        test_write_read();
        test_contention();
        test_random();
        test_reset_mid_write();
        test_wrap_full();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
